// File: rtl/div_32bits.sv
// Sequential restoring divider for MIPS DIV/DIVU: one quotient bit per clock,
// result and done pulse 32 edges after an accepted start.
module div_32bits #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] rem_reg, quo_reg, dvsr_reg, dvnd_reg;
    logic             neg_q_reg, neg_r_reg, zero_reg;
    logic [WIDTH-1:0] q_reg, r_reg;
    logic             busy_reg, done_reg, div_zero_reg;

    logic [WIDTH-1:0] dvnd_abs, dvsr_abs;
    logic [WIDTH:0]   rem_sh, diff;
    logic [WIDTH-1:0] rem_next, quo_next, q_fin, r_fin;

    assign dvnd_abs = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dvsr_abs = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;

    // rem < divisor always holds, so the 33-bit difference cannot overflow and
    // its top bit is the borrow of the trial subtraction.
    assign rem_sh   = {rem_reg, quo_reg[WIDTH-1]};
    assign diff     = rem_sh - {1'b0, dvsr_reg};
    assign rem_next = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_next = {quo_reg[WIDTH-2:0], ~diff[WIDTH]};

    assign q_fin = zero_reg ? '1       : (neg_q_reg ? -quo_next : quo_next);
    assign r_fin = zero_reg ? dvnd_reg : (neg_r_reg ? -rem_next : rem_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            dvsr_reg     <= '0;
            dvnd_reg     <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            zero_reg     <= 1'b0;
            q_reg        <= '0;
            r_reg        <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        state_reg <= RUN;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= '0;
                        rem_reg   <= '0;
                        quo_reg   <= dvnd_abs;
                        dvsr_reg  <= dvsr_abs;
                        dvnd_reg  <= dividend;
                        neg_q_reg <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r_reg <= sign & dividend[WIDTH-1];
                        zero_reg  <= (divisor == '0);
                    end
                end
                RUN: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_STEP) begin
                        state_reg    <= IDLE;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        q_reg        <= q_fin;
                        r_reg        <= r_fin;
                        div_zero_reg <= zero_reg;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign q        = q_reg;
    assign r        = r_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_div_32bits.sv
// Directed-vector bench for div_32bits: stimulus pushes expected results into a
// queue, an independent monitor pops and compares on every done pulse.
module tb_div_32bits;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sign = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] q, r;
    logic        busy, done, div_zero;

    div_32bits #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sign(sign),
        .dividend(dividend), .divisor(divisor),
        .q(q), .r(r), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    $display("txn cyc=%0d q=%h r=%h div_zero=%b", cyc, q, r, div_zero);
                    chk("q", q, mon_e.q);
                    chk("r", r, mon_e.r);
                    chk("div_zero", {31'd0, div_zero}, {31'd0, mon_e.z});
                    chk("latency", cyc, mon_e.due);
                    chk("busy_in_done", {31'd0, busy}, 32'd0);
                end
            end
        end
    end

    // Drive one start cycle at the current negedge and record the expectation.
    task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez);
        exp_t e;
        sign = s; dividend = a; divisor = b; start = 1'b1;
        e.q = eq; e.r = er; e.z = ez; e.due = cyc + 33;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez);
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
        drive(s, a, b, eq, er, ez);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_q", q, 32'd0);
        chk("rst_r", r, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
        rst_n = 1'b1;

        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        issue(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        issue(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
        issue(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
        issue(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0);
        issue(1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1);
        issue(1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1);
        issue(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // start mid-operation must be ignored; outputs hold the previous result
        issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        chk("hold_q_run", q, 32'd3);
        chk("hold_r_run", r, 32'd0);
        sign = 1'b1; dividend = 32'd7; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_ignored_start", {31'd0, busy}, 32'd1);

        // explicit back-to-back: start asserted in the done cycle
        issue(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 32'd1, 32'd0);
        drive(1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 1'b0);
        chk("done_falls_on_start", {31'd0, done}, 32'd0);

        // asynchronous reset at iteration 10 aborts with no done pulse
        issue(1'b0, 32'd12345, 32'd0, 32'hFFFFFFFF, 32'd12345, 1'b1);
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_q", q, 32'd0);
        chk("abort_r", r, 32'd0);
        sb.delete();
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_start_in_reset", {31'd0, busy}, 32'd0);
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_32bits.md
DIV_32BITS -- requirements
Module: div_32bits

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width; the only supported value is 32.
REQ-002 SHALL have port: clk  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request a division; sampled only while busy=0.
REQ-005 SHALL have port: sign  input  1  1=signed (MIPS DIV), 0=unsigned (DIVU); sampled with start.
REQ-006 SHALL have port: dividend  input  WIDTH  numerator; sampled with start.
REQ-007 SHALL have port: divisor  input  WIDTH  denominator; sampled with start.
REQ-008 SHALL have port: q  output  WIDTH  quotient (LO); registered.
REQ-009 SHALL have port: r  output  WIDTH  remainder (HI); registered.
REQ-010 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port: done  output  1  one-cycle pulse when q/r are updated.
REQ-012 SHALL have port: div_zero  output  1  divisor was zero; valid with done; held until next done.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (busy=0) and RUN (busy=1), with an iteration counter of 0..31.
REQ-014 IDLE->RUN on the edge where start=1: latch sign, |dividend|, |divisor| (absolute values only when sign=1), sign flags, zero-divisor flag; clear partial remainder; counter=0; done=0.
REQ-015 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-016 In RUN, each edge SHALL perform one restoring step: shift {rem,quo} left 1, trial-subtract divisor from rem (33-bit), keep the difference and set the quotient LSB=1 if non-negative, else restore and set the LSB=0.
REQ-017 After the 32nd step (32nd edge after the start edge), the block SHALL return RUN->IDLE, write q/r, and assert done=1 for exactly that one following cycle; busy=0 in the same cycle.
REQ-018 Latency: done SHALL be high in the cycle beginning 32 edges after the start edge, and q/r SHALL be valid from that cycle onward.
REQ-019 Signed correction: q SHALL be negated iff dividend[31]^divisor[31]; r SHALL be negated iff dividend[31]; r SHALL take the sign of the dividend (truncating division).
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL yield q=0x80000000, r=0 (32-bit wrap, no trap, no flag).
REQ-021 Divisor=0 (either mode): the block SHALL use the full 32-cycle latency; q=0xFFFFFFFF, r=dividend (original, unmodified), div_zero=1.
REQ-022 q, r, div_zero SHALL hold their last values until the next completion; they SHALL NOT change during RUN.
REQ-023 start=1 in the done cycle (busy=0) SHALL be accepted, giving back-to-back operations with no idle gap; done SHALL fall on that edge.
REQ-024 Arithmetic SHALL be internal only; no reuse of external ALU flags; subtraction width SHALL be 33 bits so no carry is lost.

Reset
REQ-025 rst_n=0 SHALL immediately (asynchronously) force IDLE, counter=0, q=0, r=0, busy=0, done=0, div_zero=0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow; the next start after rst_n=1 SHALL behave normally.
REQ-027 start SHALL be ignored while rst_n=0.

Verification
REQ-028 sign=0, 100/7 -> done 32 cycles after start; q=14, r=2, div_zero=0.
REQ-029 sign=1, 0xFFFFFFF9(-7)/2 -> q=0xFFFFFFFD(-3), r=0xFFFFFFFF(-1); sign=1, 7/0xFFFFFFFE(-2) -> q=0xFFFFFFFD, r=1.
REQ-030 sign=1, 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; sign=0, 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
REQ-031 sign=0 and sign=1, 5/0 -> q=0xFFFFFFFF, r=5, div_zero=1; a following 9/3 -> q=3, r=0, div_zero=0.
REQ-032 start pulsed at cycle 10 of an operation -> ignored, result unchanged; start held in the done cycle -> second result done exactly 32 cycles later.
REQ-033 rst_n low at iteration 10 -> busy/q/r=0 without waiting for a clock edge, no done; a new 100/7 after release -> q=14, r=2.
